// File: rtl/rr_arb_code.sv
// Four-requester round-robin arbiter producing {valid, idx[1:0]} for a 2-to-4 decoder.
// Each requester holds the grant for at most HOLD_MAX consecutive cycles while others wait.
// The released requester becomes lowest priority in the next search.
// Optional macro ARB_LOCK_EN adds a 'lock' input that suppresses the forced rotation.
// HOLD_MAX must be in 1..15, and 2**CNT_W must be greater than HOLD_MAX.
module rr_arb_code #(
  parameter int unsigned HOLD_MAX = 4,
  parameter int unsigned CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
`ifdef ARB_LOCK_EN
  input  logic       lock,
`endif
  output logic [2:0] code,
  output logic       busy
);

  localparam int unsigned IDX_W = 2;
  localparam int unsigned NREQ  = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t           state_q;
  logic [2:0]       code_q;
  logic             busy_q;
  logic [IDX_W-1:0] last_q;
  logic [CNT_W-1:0] hold_q;

  logic             lock_c;
  logic [IDX_W-1:0] g_c;
  logic [NREQ-1:0]  others_c;
  logic [IDX_W-1:0] idle_pick_c;
  logic [IDX_W-1:0] rel_pick_c;
  logic             hold_max_c;

  // First set request found scanning upward from 'start' with wrap-around.
  // Callers only use the result when 'r' is nonzero.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NREQ-1:0] r,
                                               input logic [IDX_W-1:0] start);
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] res;
    res = start;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = start + IDX_W'(k);
      if (r[idx]) res = idx;
    end
    return res;
  endfunction

`ifdef ARB_LOCK_EN
  assign lock_c = lock;
`else
  assign lock_c = 1'b0;
`endif

  // Search candidates: from last+1 when idle, from g+1 excluding g when granted.
  assign g_c         = code_q[IDX_W-1:0];
  assign others_c    = req & ~(NREQ'(1) << g_c);
  assign idle_pick_c = rr_pick(req, last_q + IDX_W'(1));
  assign rel_pick_c  = rr_pick(others_c, g_c + IDX_W'(1));
  assign hold_max_c  = (hold_q == CNT_W'(HOLD_MAX));

  // Arbitration FSM with registered code/busy outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      code_q  <= 3'b000;
      busy_q  <= 1'b0;
      last_q  <= IDX_W'(NREQ - 1);
      hold_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|req) begin
            state_q <= GRANT;
            code_q  <= {1'b1, idle_pick_c};
            busy_q  <= 1'b1;
            hold_q  <= CNT_W'(1);
          end else begin
            code_q  <= 3'b000;
            busy_q  <= 1'b0;
          end
        end
        GRANT: begin
          if (!req[g_c]) begin
            // Voluntary release: hand over on the same edge or go idle.
            last_q <= g_c;
            if (|req) begin
              code_q <= {1'b1, rel_pick_c};
              hold_q <= CNT_W'(1);
            end else begin
              state_q <= IDLE;
              code_q  <= 3'b000;
              busy_q  <= 1'b0;
              hold_q  <= '0;
            end
          end else if (hold_max_c) begin
            // Hold budget spent: rotate if someone waits, else stay saturated.
            if ((|others_c) && !lock_c) begin
              last_q <= g_c;
              code_q <= {1'b1, rel_pick_c};
              hold_q <= CNT_W'(1);
            end
          end else begin
            hold_q <= hold_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          code_q  <= 3'b000;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign code = code_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_rr_arb_code.sv
// Self-checking bench for rr_arb_code: directed scenarios plus randomized
// requests compared against a behavioural round-robin reference model.
module tb_rr_arb_code;

  localparam int HOLD = 4;

  logic       clk;
  logic       rst;
  logic [3:0] req;
`ifdef ARB_LOCK_EN
  logic       lock;
`endif
  logic [2:0] code;
  logic       busy;

  int checks;
  int failures;

  // Reference model state
  bit m_act;
  int m_g;
  int m_last;
  int m_cnt;

  rr_arb_code #(.HOLD_MAX(HOLD), .CNT_W(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
`ifdef ARB_LOCK_EN
    .lock (lock),
`endif
    .code (code),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit cur_lock();
`ifdef ARB_LOCK_EN
    return lock;
`else
    return 1'b0;
`endif
  endfunction

  // Index of first requester at or after s, wrapping; -1 if none.
  function automatic int pick(input logic [3:0] r, input int s);
    for (int k = 0; k < 4; k++) begin
      if (r[(s + k) % 4]) return (s + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_act  = 1'b0;
    m_g    = 0;
    m_last = 3;
    m_cnt  = 0;
  endtask

  task automatic model_step(input logic [3:0] r, input bit lk);
    logic [3:0] others;
    if (!m_act) begin
      if (r != 4'b0000) begin
        m_act = 1'b1;
        m_g   = pick(r, (m_last + 1) % 4);
        m_cnt = 1;
      end
    end else begin
      others = r;
      others[m_g] = 1'b0;
      if (!r[m_g]) begin
        m_last = m_g;
        if (r != 4'b0000) begin
          m_g   = pick(r, (m_g + 1) % 4);
          m_cnt = 1;
        end else begin
          m_act = 1'b0;
          m_cnt = 0;
        end
      end else if (m_cnt >= HOLD) begin
        if (others != 4'b0000 && !lk) begin
          m_last = m_g;
          m_g    = pick(others, (m_g + 1) % 4);
          m_cnt  = 1;
        end
      end else begin
        m_cnt = m_cnt + 1;
      end
    end
  endtask

  function automatic logic [2:0] exp_code();
    return m_act ? {1'b1, 2'(m_g)} : 3'b000;
  endfunction

  // Apply req, clock once, update the model, and leave time 1 after the edge.
  task automatic tick(input logic [3:0] r);
    req = r;
    @(posedge clk);
    #1;
    if (rst) model_reset();
    else model_step(r, cur_lock());
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(req);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [2:0] want;
    rst = 1'b1;
    tick(4'b1111);
    tick(4'b1111);
    checks++;
    if (code !== 3'b000 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_hold: code=%b busy=%b want code=000 busy=0", code, busy);
    end
    rst = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick(4'b1111);
      want = (i <= 4) ? 3'b100 : 3'b101;
      checks++;
      if (code !== want || busy !== 1'b1) begin
        failures++;
        $display("FAIL reset_first_grant cyc%0d: code=%b busy=%b want code=%b busy=1",
                 i, code, busy, want);
      end
    end
  endtask

  task automatic test_no_bubble();
    do_reset();
    tick(4'b1010);
    checks++;
    if (code !== 3'b101) begin
      failures++;
      $display("FAIL no_bubble_first: code=%b want 101", code);
    end
    tick(4'b1000);
    checks++;
    if (code !== 3'b111 || busy !== 1'b1) begin
      failures++;
      $display("FAIL no_bubble_handover: code=%b busy=%b want code=111 busy=1", code, busy);
    end
    tick(4'b0000);
    checks++;
    if (code !== 3'b000 || busy !== 1'b0) begin
      failures++;
      $display("FAIL no_bubble_idle: code=%b busy=%b want code=000 busy=0", code, busy);
    end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 10; i++) begin
      tick(4'b0100);
      checks++;
      if (code !== 3'b110 || busy !== 1'b1) begin
        failures++;
        $display("FAIL saturate cyc%0d: code=%b busy=%b want code=110 busy=1", i, code, busy);
      end
    end
    tick(4'b0000);
  endtask

  task automatic test_wrap();
    tick(4'b1000);
    checks++;
    if (code !== 3'b111) begin
      failures++;
      $display("FAIL wrap_grant3: code=%b want 111", code);
    end
    tick(4'b0001);
    checks++;
    if (code !== 3'b100) begin
      failures++;
      $display("FAIL wrap_release: code=%b want 100", code);
    end
    tick(4'b1000);
    checks++;
    if (code !== 3'b111) begin
      failures++;
      $display("FAIL wrap_regrant3: code=%b want 111", code);
    end
    // Forced rotation from idx 3 must wrap to idx 0 after HOLD cycles.
    for (int i = 2; i <= HOLD + 1; i++) begin
      tick(4'b1001);
      checks++;
      if (code !== ((i <= HOLD) ? 3'b111 : 3'b100)) begin
        failures++;
        $display("FAIL wrap_forced cyc%0d: code=%b want %b", i, code,
                 (i <= HOLD) ? 3'b111 : 3'b100);
      end
    end
    tick(4'b0000);
  endtask

  task automatic test_async_reset();
    do_reset();
    tick(4'b0100);
    checks++;
    if (code !== 3'b110) begin
      failures++;
      $display("FAIL async_pre: code=%b want 110", code);
    end
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if (code !== 3'b000 || busy !== 1'b0) begin
      failures++;
      $display("FAIL async_drop: code=%b busy=%b want code=000 busy=0", code, busy);
    end
    #1;
    rst = 1'b0;
    tick(4'b0100);
    checks++;
    if (code !== 3'b110) begin
      failures++;
      $display("FAIL async_after: code=%b want 110", code);
    end
    tick(4'b0000);
  endtask

`ifdef ARB_LOCK_EN
  task automatic test_lock();
    do_reset();
    lock = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(4'b0011);
      checks++;
      if (code !== 3'b100) begin
        failures++;
        $display("FAIL lock_hold cyc%0d: code=%b want 100", i, code);
      end
    end
    lock = 1'b0;
    tick(4'b0011);
    checks++;
    if (code !== 3'b101) begin
      failures++;
      $display("FAIL lock_release: code=%b want 101", code);
    end
    tick(4'b0000);
  endtask
`endif

  task automatic test_random();
    logic [3:0] r;
    logic [2:0] want;
    r = 4'b0000;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        rst = 1'b1;
        tick(r);
        rst = 1'b0;
      end
      if ($urandom_range(0, 9) == 0) r = 4'b0000;
      else if ($urandom_range(0, 2) == 0) r = 4'($urandom);
`ifdef ARB_LOCK_EN
      if ($urandom_range(0, 7) == 0) lock = ~lock;
`endif
      tick(r);
      want = exp_code();
      checks++;
      if (code !== want || busy !== want[2]) begin
        failures++;
        $display("FAIL random cyc%0d req=%b: code=%b busy=%b want code=%b busy=%b",
                 i, r, code, busy, want, want[2]);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    req      = 4'b0000;
`ifdef ARB_LOCK_EN
    lock     = 1'b0;
`endif
    model_reset();
    test_reset();
    test_no_bubble();
    test_saturate();
    test_wrap();
    test_async_reset();
`ifdef ARB_LOCK_EN
    test_lock();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
